axi_lite_reg_slave: RTL

- AXI4-Lite slave endpoint holding a bank of 32-bit registers.
- Sits directly downstream of axi_lite_interconnect and is attached to one slave port of it.
- Accepts write address and write data independently, applies byte strobes, and returns OKAY/SLVERR responses.
- Register 0 is a read-only ID register; registers 1..NUM_REGS-1 are read/write.

---
 rtl/axi_lite_reg_slave.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register slave: read-only ID at register 0, byte-strobed R/W registers above it.
// Independent AW/W holding buffers, one outstanding write and one outstanding read.
module axi_lite_reg_slave #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          NUM_REGS  = 16,
   parameter logic [31:0] ID_VALUE  = 32'hA11E_0001
) (
   input  logic        aclk,
   input  logic        areset_n,
   input  logic [31:0] awaddr,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wvalid,
   output logic        wready,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready,
   input  logic [31:0] araddr,
   input  logic        arvalid,
   output logic        arready,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rvalid,
   input  logic        rready
);

   localparam int         IDX_W  = $clog2(NUM_REGS);
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   logic              ready_en;
   logic              aw_full;
   logic              w_full;
   logic [31:0]       aw_addr_q;
   logic [31:0]       w_data_q;
   logic [3:0]        w_strb_q;
   logic [31:0]       regs [NUM_REGS];

   logic              aw_hs;
   logic              w_hs;
   logic              ar_hs;
   logic              commit;
   logic [31:0]       wr_addr;
   logic [31:0]       wr_data;
   logic [3:0]        wr_strb;
   logic [31:0]       wr_off;
   logic [31:0]       rd_off;
   logic [IDX_W-1:0]  wr_idx;
   logic [IDX_W-1:0]  rd_idx;
   logic              wr_in_range;
   logic              rd_in_range;
   logic              unused_bits;

   // Readies stay low until the first clock edge after reset release.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) ready_en <= 1'b0;
      else           ready_en <= 1'b1;
   end

   assign awready = ready_en & ~aw_full & ~bvalid;
   assign wready  = ready_en & ~w_full & ~bvalid;
   assign arready = ready_en & ~rvalid;

   assign aw_hs = awvalid & awready;
   assign w_hs  = wvalid & wready;
   assign ar_hs = arvalid & arready;

   // Commit uses the live channel when its buffer is empty, so a same-cycle
   // AW+W pair completes without first passing through the buffers.
   assign commit  = (aw_full | aw_hs) & (w_full | w_hs);
   assign wr_addr = aw_full ? aw_addr_q : awaddr;
   assign wr_data = w_full ? w_data_q : wdata;
   assign wr_strb = w_full ? w_strb_q : wstrb;

   assign wr_off      = wr_addr - BASE_ADDR;
   assign wr_idx      = wr_off[IDX_W+1:2];
   assign wr_in_range = (wr_off[31:IDX_W+2] == '0);

   assign rd_off      = araddr - BASE_ADDR;
   assign rd_idx      = rd_off[IDX_W+1:2];
   assign rd_in_range = (rd_off[31:IDX_W+2] == '0);

   assign unused_bits = ^{wr_off[1:0], rd_off[1:0]};

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         aw_full   <= 1'b0;
         w_full    <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bvalid    <= 1'b0;
         bresp     <= OKAY;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         if (bvalid && bready) bvalid <= 1'b0;
         if (commit) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= wr_in_range ? OKAY : SLVERR;
            if (wr_in_range && (wr_idx != '0)) begin
               for (int b = 0; b < 4; b++) begin
                  if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
               end
            end
         end else begin
            if (aw_hs) begin
               aw_full   <= 1'b1;
               aw_addr_q <= awaddr;
            end
            if (w_hs) begin
               w_full   <= 1'b1;
               w_data_q <= wdata;
               w_strb_q <= wstrb;
            end
         end
      end
   end

   // Reads sample the register array before any same-edge commit lands.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         rvalid <= 1'b0;
         rdata  <= '0;
         rresp  <= OKAY;
      end else if (ar_hs) begin
         rvalid <= 1'b1;
         if (!rd_in_range) begin
            rdata <= '0;
            rresp <= SLVERR;
         end else if (rd_idx == '0) begin
            rdata <= ID_VALUE;
            rresp <= OKAY;
         end else begin
            rdata <= regs[rd_idx];
            rresp <= OKAY;
         end
      end else if (rvalid && rready) begin
         rvalid <= 1'b0;
      end
   end

endmodule
